// File: rtl/ysyx_23060221_wbu_pkg.sv
// rtl/ysyx_23060221_wbu_pkg.sv - shared constants and types for the write-back stage
package ysyx_23060221_wbu_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] CSROP_NONE  = 3'd0;
  localparam logic [2:0] CSROP_CSRRW = 3'd1;
  localparam logic [2:0] CSROP_CSRRS = 3'd2;
  localparam logic [2:0] CSROP_ECALL = 3'd3;
  localparam logic [2:0] CSROP_MRET  = 3'd4;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  typedef enum logic {
    WBU_ACCEPT = 1'b0,
    WBU_ISSUE  = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_23060221_regfile.sv
// rtl/ysyx_23060221_regfile.sv - 32x32 register file, two async reads, one sync write
module ysyx_23060221_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  // Contents are deliberately left unreset; entry 0 is never written.
  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/ysyx_23060221_wbu.sv
// rtl/ysyx_23060221_wbu.sv - write-back stage: register/CSR commit and next-PC issue
module ysyx_23060221_wbu
  import ysyx_23060221_wbu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXU_valid,
  output logic        WBU_ready,
  input  logic [31:0] wd,
  input  logic [4:0]  rd,
  input  logic        regwr,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] src1,
  input  logic        PCAsrc,
  input  logic        PCBsrc,
  input  logic [2:0]  csrop,
  input  logic [11:0] csraddr,
  output logic        WBU_valid,
  input  logic        IFU_ready,
  output logic [31:0] dnpc,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  wbu_state_e  state_q, state_d;
  logic [31:0] dnpc_q, dnpc_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic        accept;
  logic        is_csrrw, is_csrrs, is_ecall, is_mret, is_csr_rmw;
  logic [31:0] csr_old, csr_new;
  logic [31:0] pc_base, pc_sum, pc_seq, pc_next;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign accept     = (state_q == WBU_ACCEPT) && EXU_valid;
  assign is_csrrw   = (csrop == CSROP_CSRRW);
  assign is_csrrs   = (csrop == CSROP_CSRRS);
  assign is_ecall   = (csrop == CSROP_ECALL);
  assign is_mret    = (csrop == CSROP_MRET);
  assign is_csr_rmw = is_csrrw || is_csrrs;

  // Unimplemented CSR indices read as zero.
  always_comb begin
    csr_old = 32'd0;
    case (csraddr)
      CSR_MSTATUS: csr_old = mstatus_q;
      CSR_MTVEC:   csr_old = mtvec_q;
      CSR_MEPC:    csr_old = mepc_q;
      CSR_MCAUSE:  csr_old = mcause_q;
      default:     csr_old = 32'd0;
    endcase
  end

  assign csr_new = is_csrrw ? src1 : (csr_old | src1);

  // jalr targets drop bit 0 of the sum; branches and sequential flow never set it.
  assign pc_base = PCBsrc ? src1 : pc;
  assign pc_sum  = pc_base + (PCAsrc ? imm : 32'd4);
  assign pc_seq  = {pc_sum[31:1], pc_sum[0] & ~PCBsrc};

  always_comb begin
    pc_next = pc_seq;
    if (is_ecall) begin
      pc_next = mtvec_q;
    end else if (is_mret) begin
      pc_next = mepc_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    dnpc_d    = dnpc_q;
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    case (state_q)
      WBU_ACCEPT: begin
        if (EXU_valid) begin
          state_d = WBU_ISSUE;
          dnpc_d  = pc_next;
          if (is_csr_rmw) begin
            case (csraddr)
              CSR_MSTATUS: mstatus_d = csr_new;
              CSR_MTVEC:   mtvec_d   = csr_new;
              CSR_MEPC:    mepc_d    = csr_new;
              CSR_MCAUSE:  mcause_d  = csr_new;
              default:     ;
            endcase
          end
          if (is_ecall) begin
            mepc_d   = pc;
            mcause_d = MCAUSE_ECALL_M;
          end
        end
      end
      WBU_ISSUE: begin
        if (IFU_ready) begin
          state_d = WBU_ACCEPT;
        end
      end
      default: state_d = WBU_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WBU_ISSUE;
      dnpc_q    <= RESET_PC;
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= 32'd0;
      mepc_q    <= 32'd0;
      mcause_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      dnpc_q    <= dnpc_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // ecall never writes rd, whatever regwr says.
  assign rf_we    = accept && regwr && (rd != 5'd0) && !is_ecall;
  assign rf_wdata = is_csr_rmw ? csr_old : wd;

  ysyx_23060221_regfile u_regfile (
    .clk      (clk),
    .we_i     (rf_we),
    .waddr_i  (rd),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign WBU_ready = (state_q == WBU_ACCEPT);
  assign WBU_valid = (state_q == WBU_ISSUE);
  assign dnpc      = dnpc_q;

endmodule

// File: tb/tb_ysyx_23060221_wbu.sv
// tb/tb_ysyx_23060221_wbu.sv - directed self-checking bench for the write-back stage
module tb_ysyx_23060221_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EXU_valid = 1'b0;
  logic        WBU_ready;
  logic [31:0] wd = '0;
  logic [4:0]  rd = '0;
  logic        regwr = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] src1 = '0;
  logic        PCAsrc = 1'b0;
  logic        PCBsrc = 1'b0;
  logic [2:0]  csrop = '0;
  logic [11:0] csraddr = '0;
  logic        WBU_valid;
  logic        IFU_ready = 1'b0;
  logic [31:0] dnpc;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ysyx_23060221_wbu dut (
    .clk       (clk),
    .rst       (rst),
    .EXU_valid (EXU_valid),
    .WBU_ready (WBU_ready),
    .wd        (wd),
    .rd        (rd),
    .regwr     (regwr),
    .pc        (pc),
    .imm       (imm),
    .src1      (src1),
    .PCAsrc    (PCAsrc),
    .PCBsrc    (PCBsrc),
    .csrop     (csrop),
    .csraddr   (csraddr),
    .WBU_valid (WBU_valid),
    .IFU_ready (IFU_ready),
    .dnpc      (dnpc),
    .rs1       (rs1),
    .rs2       (rs2),
    .rdata1    (rdata1),
    .rdata2    (rdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [31:0] pc_v, input logic [31:0] imm_v, input logic [31:0] src1_v,
                       input logic pa, input logic pb, input logic [2:0] op, input logic [11:0] ca,
                       input logic [4:0] rd_v, input logic rw, input logic [31:0] wd_v);
    pc = pc_v; imm = imm_v; src1 = src1_v; PCAsrc = pa; PCBsrc = pb;
    csrop = op; csraddr = ca; rd = rd_v; regwr = rw; wd = wd_v;
  endtask

  task automatic accept_cycle();
    EXU_valid = 1'b1;
    @(posedge clk); #1;
    EXU_valid = 1'b0;
  endtask

  task automatic ifu_pulse();
    IFU_ready = 1'b1;
    @(posedge clk); #1;
    IFU_ready = 1'b0;
  endtask

  initial begin
    // reset held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, WBU_valid}, 32'd1);
    chk("rst_ready", {31'd0, WBU_ready}, 32'd0);
    chk("rst_dnpc", dnpc, 32'h8000_0000);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("boot_valid", {31'd0, WBU_valid}, 32'd1);
    chk("boot_dnpc", dnpc, 32'h8000_0000);
    ifu_pulse();
    chk("boot_ready", {31'd0, WBU_ready}, 32'd1);
    chk("boot_valid_lo", {31'd0, WBU_valid}, 32'd0);

    // sequential + rd write
    setup(32'h8000_0010, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 12'h0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    rs1 = 5'd5;
    accept_cycle();
    chk("seq_valid", {31'd0, WBU_valid}, 32'd1);
    chk("seq_ready", {31'd0, WBU_ready}, 32'd0);
    chk("seq_dnpc", dnpc, 32'h8000_0014);
    chk("seq_x5", rdata1, 32'hDEAD_BEEF);
    ifu_pulse();

    // jalr, rd=0
    setup(32'h8000_0020, 32'h4, 32'h8000_0103, 1'b1, 1'b1, 3'd0, 12'h0, 5'd0, 1'b1, 32'h1234_5678);
    rs2 = 5'd0;
    accept_cycle();
    chk("jalr_dnpc", dnpc, 32'h8000_0106);
    chk("jalr_x0", rdata2, 32'h0);
    ifu_pulse();

    // branch-style pc+imm
    setup(32'h8000_0030, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 3'd0, 12'h0, 5'd0, 1'b0, 32'h0);
    accept_cycle();
    chk("br_dnpc", dnpc, 32'h8000_0020);
    ifu_pulse();

    // csrrw mtvec
    setup(32'h8000_0020, 32'h0, 32'h8000_0200, 1'b0, 1'b0, 3'd1, 12'h305, 5'd6, 1'b1, 32'h5555_5555);
    rs1 = 5'd6;
    accept_cycle();
    chk("csrrw_dnpc", dnpc, 32'h8000_0024);
    chk("csrrw_x6", rdata1, 32'h0);
    ifu_pulse();

    // ecall with rd=5 and regwr=1: x5 must stay
    setup(32'h8000_0040, 32'h0, 32'h0, 1'b0, 1'b0, 3'd3, 12'h0, 5'd5, 1'b1, 32'h0000_0055);
    rs1 = 5'd5;
    accept_cycle();
    chk("ecall_dnpc", dnpc, 32'h8000_0200);
    chk("ecall_x5", rdata1, 32'hDEAD_BEEF);
    ifu_pulse();

    // read mepc / mcause
    setup(32'h8000_0200, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 12'h341, 5'd8, 1'b1, 32'h0);
    rs1 = 5'd8;
    accept_cycle();
    chk("mepc", rdata1, 32'h8000_0040);
    chk("mepc_dnpc", dnpc, 32'h8000_0204);
    ifu_pulse();
    setup(32'h8000_0204, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 12'h342, 5'd9, 1'b1, 32'h0);
    rs1 = 5'd9;
    accept_cycle();
    chk("mcause", rdata1, 32'd11);
    ifu_pulse();

    // mret
    setup(32'h8000_0208, 32'h0, 32'h0, 1'b0, 1'b0, 3'd4, 12'h0, 5'd0, 1'b0, 32'h0);
    accept_cycle();
    chk("mret_dnpc", dnpc, 32'h8000_0040);
    ifu_pulse();

    // csrrs mstatus
    setup(32'h8000_0040, 32'h0, 32'h8, 1'b0, 1'b0, 3'd2, 12'h300, 5'd10, 1'b1, 32'h0);
    rs1 = 5'd10;
    accept_cycle();
    chk("csrrs_old", rdata1, 32'h0000_1800);
    ifu_pulse();
    setup(32'h8000_0044, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 12'h300, 5'd11, 1'b1, 32'h0);
    rs1 = 5'd11;
    accept_cycle();
    chk("csrrs_new", rdata1, 32'h0000_1808);
    ifu_pulse();

    // unimplemented CSR
    setup(32'h8000_0048, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd1, 12'h7C0, 5'd12, 1'b1, 32'h9999_9999);
    rs1 = 5'd12;
    accept_cycle();
    chk("unimp_rw", rdata1, 32'h0);
    ifu_pulse();
    setup(32'h8000_004C, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 12'h7C0, 5'd13, 1'b1, 32'h9999_9999);
    rs1 = 5'd13;
    accept_cycle();
    chk("unimp_rs", rdata1, 32'h0);
    ifu_pulse();
    setup(32'h8000_0050, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 12'h300, 5'd13, 1'b1, 32'h0);
    accept_cycle();
    chk("unimp_mstatus", rdata1, 32'h0000_1808);
    ifu_pulse();

    // no bypass on same-cycle read
    setup(32'h8000_0060, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 12'h0, 5'd5, 1'b1, 32'h1111_1111);
    rs1 = 5'd5;
    EXU_valid = 1'b1;
    #1;
    chk("nobypass_old", rdata1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("nobypass_new", rdata1, 32'h1111_1111);
    chk("nobypass_dnpc", dnpc, 32'h8000_0064);

    // EXU_valid held through ISSUE is ignored
    setup(32'h8000_0070, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 12'h0, 5'd5, 1'b1, 32'h2222_2222);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_valid", {31'd0, WBU_valid}, 32'd1);
    chk("stall_dnpc", dnpc, 32'h8000_0064);
    chk("stall_x5", rdata1, 32'h1111_1111);
    EXU_valid = 1'b0;
    ifu_pulse();
    chk("stall_ready", {31'd0, WBU_ready}, 32'd1);

    // async reset mid-ISSUE
    setup(32'h8000_0080, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 12'h0, 5'd0, 1'b0, 32'h0);
    accept_cycle();
    chk("pre_rst_dnpc", dnpc, 32'h8000_0084);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dnpc", dnpc, 32'h8000_0000);
    chk("arst_valid", {31'd0, WBU_valid}, 32'd1);
    chk("arst_ready", {31'd0, WBU_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    ifu_pulse();

    // CSRs reset: mstatus back to 0x1800, ecall with mtvec=0 goes to 0
    setup(32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 12'h300, 5'd14, 1'b1, 32'h0);
    rs1 = 5'd14;
    accept_cycle();
    chk("rst_mstatus", rdata1, 32'h0000_1800);
    ifu_pulse();
    setup(32'h8000_0004, 32'h0, 32'h0, 1'b0, 1'b0, 3'd3, 12'h0, 5'd0, 1'b0, 32'h0);
    accept_cycle();
    chk("ecall_mtvec0", dnpc, 32'h0);
    ifu_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060221_wbu.md
# ysyx_23060221_wbu

Write-back stage of the multi-cycle core, directly downstream of the execute stage. It accepts one retired instruction per EXU→WBU handshake and commits its register-file write and CSR update. It computes the next PC (sequential, branch/jump, trap, trap return) and offers it to the fetch stage over a valid/ready handshake. It owns the 32×32 general register file, whose read ports serve the decode stage, and the machine-mode CSRs.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first PC offered to fetch after reset
- MSTATUS_RST, 32'h0000_1800, mstatus reset value

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-low
- EXU_valid  in  1  execute result valid
- WBU_ready  out  1  WBU can accept a result
- wd  in  32  ALU/load result for rd
- rd  in  5  destination register index
- regwr  in  1  write rd
- pc  in  32  PC of the retiring instruction
- imm  in  32  immediate
- src1  in  32  rs1 value
- PCAsrc  in  1  addend select: 1 = imm, 0 = 4
- PCBsrc  in  1  base select: 1 = src1 (jalr), 0 = pc
- csrop  in  3  0 none, 1 csrrw, 2 csrrs, 3 ecall, 4 mret, others = none
- csraddr  in  12  CSR index
- WBU_valid  out  1  dnpc valid toward fetch
- IFU_ready  in  1  fetch accepts dnpc
- dnpc  out  32  next PC
- rs1, rs2  in  5 each  decode read indices
- rdata1, rdata2  out  32 each  combinational register reads; index 0 reads 0

## Operation
- Two states: ACCEPT (WBU_ready=1, WBU_valid=0) and ISSUE (WBU_ready=0, WBU_valid=1).
- Reset enters ISSUE with dnpc=RESET_PC. This boots fetch.
- ISSUE → ACCEPT on IFU_ready.
- ACCEPT → ISSUE on EXU_valid. All commit actions occur on that edge.
- Register write data:
  - csrop 1/2: old CSR value.
  - Otherwise: wd.
  - Written only when regwr=1 and rd≠0. x0 is never stored.
- CSRs:
  - Implemented: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. Other indices read 0 and ignore writes.
  - csrrw: new value = src1.
  - csrrs: new value = old | src1.
  - ecall: mepc←pc, mcause←32'd11; no rd write regardless of regwr.
  - mret: no CSR write.
- Next PC:
  - ecall → mtvec.
  - mret → mepc.
  - Otherwise (PCBsrc ? src1 : pc) + (PCAsrc ? imm : 4), modulo 2^32, with bit0 cleared when PCBsrc=1.
- dnpc is registered and stable throughout ISSUE.
- ecall with mtvec's reset value (0) is legal and yields dnpc=0.

## Timing
- Reset values:
  - WBU_ready=0, WBU_valid=1, dnpc=RESET_PC.
  - mstatus=MSTATUS_RST; mtvec, mepc, mcause = 0.
  - Registers x1–x31 are not reset.
- Latency: accept edge N → WBU_valid=1 with new dnpc in cycle N+1. Written register readable on rdata in N+1.
- A same-cycle read of the register being written returns the old value; there is no bypass.
- An IFU_ready held high in ISSUE completes in one cycle. WBU_ready returns to 1 in the following cycle.
- EXU_valid while in ISSUE is ignored. EXU holds its data until handshake.
- rst asserted mid-ISSUE or mid-accept aborts immediately. No partial commit is visible after reset, except that register-file contents are undefined.

## Structure
- Shared package holds:
  - CSR index constants CSR_MSTATUS/MTVEC/MEPC/MCAUSE.
  - csrop encodings.
  - MCAUSE_ECALL_M=11.
  - The WBU state enum.
- One sub-module ysyx_23060221_regfile: 2 async read ports, 1 sync write port, x0 hardwired to zero.
- CSR file and next-PC logic stay inline.

## Test plan
- Reset release → WBU_valid=1, dnpc=32'h8000_0000; IFU_ready pulse → WBU_ready=1 next cycle.
- Handshake with pc=0x8000_0010, PCAsrc=0, rd=5, wd=0xDEAD_BEEF, regwr=1 → dnpc=0x8000_0014; rs1=5 reads 0xDEAD_BEEF next cycle.
- jalr: src1=0x8000_0103, imm=4, PCBsrc=PCAsrc=1 → dnpc=0x8000_0106. rd=0 with regwr=1 → x0 still reads 0.
- Mtvec handling:
  - csrrw mtvec with src1=0x8000_0200 and rd=6 → x6=0.
  - Then ecall at pc=0x8000_0040 → dnpc=0x8000_0200, mepc=0x8000_0040, mcause=11.
  - Then mret → dnpc=0x8000_0040.
- csrrs mstatus with src1=0x8 → rd=0x1800, mstatus becomes 0x1808. csraddr=0x7C0 → rd=0, no state change.
- Abort and stall:
  - Assert rst during ISSUE with IFU_ready low → outputs return to reset values asynchronously, before the next edge.
  - EXU_valid held high during ISSUE is not accepted.
